sst_descrambler: RTL and testbench
==================================

// Module: sst_descrambler
// PURPOSE
//  Self-synchronising (multiplicative) XOR descrambler: receive-side counterpart
//  of the link scrambler built from the GTECH XOR primitives.
//  Accepts W-bit scrambled words over valid/ready and undoes the scrambling
//    d = s ^ XOR(history & TAPS), using a LEN-bit history of received scrambled bits.
//  Returns the descrambled words through a 1-deep registered output stage.
//  Flags each output word as synchronised or not.
// PARAMETERS
//  W      8               data word width, bits per beat (1..64)
//  LEN    7               scrambler history length = polynomial degree
//  TAPS   7'b1100000      bit k set => term x^(k+1); default x^7+x^6+1
// PORTS
//  CLK        in   1    rising-edge clock
//  RST_N      in   1    asynchronous active-low reset
//  IN_VALID   in   1    scrambled word present on IN_DATA
//  IN_READY   out  1    block accepts IN_DATA this cycle
//  IN_DATA    in   W    scrambled word; bit 0 is first on the wire
//  RESYNC     in   1    synchronous pulse: flush history, restart fill
//  OUT_VALID  out  1    descrambled word present on OUT_DATA
//  OUT_READY  in   1    downstream accepts OUT_DATA this cycle
//  OUT_DATA   out  W    descrambled word
//  OUT_SYNC   out  1    qualifies OUT_DATA: history was fully populated
//  SYNC       out  1    state == SYNC
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - history=0, fill=0, state=FILL
//   - OUT_VALID=0, OUT_DATA=0, OUT_SYNC=0, SYNC=0
//  Handshake:
//   - IN_READY = !OUT_VALID | OUT_READY (combinational)
//   - accept = IN_VALID & IN_READY
//   - On accept, the output register loads on the same edge; latency 1 cycle.
//   - OUT_VALID clears on OUT_READY without a new accept.
//   - OUT_DATA and OUT_SYNC are held stable while OUT_VALID & !OUT_READY.
//  Per-accepted-word datapath, bits processed i=0..W-1 in order (r = history):
//   - d[i] = s[i] ^ ^(r & TAPS)
//   - then r = {r[LEN-2:0], s[i]}; r[0] is the newest bit
//   - Fully combinational unroll in a single cycle.
//  Fill counter, width clog2(LEN+W)+1:
//   - adds W per accept
//   - saturates at LEN, no wrap
//  States:
//   - FILL -> SYNC when the post-accept fill >= LEN
//   - SYNC -> FILL only on RESYNC
//  OUT_SYNC for a word = 1 iff fill >= LEN before that word's first bit.
//   - Default config: word 1 after reset is OUT_SYNC=0, word 2 onward is 1.
//  RESYNC:
//   - effective next edge: history=0, fill=0, state=FILL
//   - an output word already held is kept
//   - RESYNC & accept in the same cycle: RESYNC wins
//      - the accepted word is descrambled with history=0
//      - that word's OUT_SYNC=0
//      - post-edge fill = W (saturated at LEN), history = that word's bits
//  Async reset mid-transfer:
//   - drops any held output word
//   - no further output until a new accept
// TESTING
//  T1 reset, accept IN_DATA=0x01 -> next cycle OUT_DATA=0xC1, OUT_SYNC=0, SYNC=1
//  T2 ref scrambler fed 256 random words -> output matches source from word 2, OUT_SYNC=1
//  T3 OUT_READY=0 for 5 cycles with IN_VALID=1 -> IN_READY=0, OUT_DATA stable, no loss or dup
//  T4 mid-stream RESYNC -> next word OUT_SYNC=0, SYNC=0 one cycle, stream correct afterwards
//  T5 RST_N=0 while OUT_VALID=1 & !OUT_READY -> OUT_VALID=0 immediately, state=FILL
//  T6 W=1, LEN=7 build -> OUT_SYNC rises on the 8th accepted bit, SYNC after the 7th

Source files
------------

// File: rtl/sst_descrambler.sv
// Self-synchronising multiplicative XOR descrambler with a valid/ready input and a
// one-deep registered output stage; each word is flagged when decoded from a full history.
module sst_descrambler #(
    parameter int unsigned    W    = 8,
    parameter int unsigned    LEN  = 7,
    parameter logic [LEN-1:0] TAPS = LEN'(7'b1100000)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         resync,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sync,
    output logic         sync
);
    localparam int unsigned   FW        = $clog2(LEN + W) + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0] FILL_STEP = FW'(W);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_SYNC = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_sync_q, out_sync_d;

    logic           accept;
    logic [LEN-1:0] hist_base;
    logic [LEN-1:0] hist_walk;
    logic [FW-1:0]  fill_base;
    logic [FW-1:0]  fill_sum;
    logic [FW-1:0]  fill_sat;
    logic [W-1:0]   word;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A RESYNC in the same cycle as an accept decodes that word from a cleared history.
    always_comb begin : descramble
        hist_base = resync ? '0 : hist_q;
        fill_base = resync ? '0 : fill_q;
        hist_walk = hist_base;
        word      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            word[i]   = in_data[i] ^ (^(hist_walk & TAPS));
            hist_walk = LEN'({hist_walk, in_data[i]});
        end
        fill_sum = fill_base + FILL_STEP;
        fill_sat = (fill_sum >= FILL_FULL) ? FILL_FULL : fill_sum;
    end

    always_comb begin : next_state
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sync_d  = out_sync_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (resync) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end

        if (accept) begin
            hist_d      = hist_walk;
            fill_d      = fill_sat;
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_sync_d  = (fill_base >= FILL_FULL);
            if (!resync && (fill_sat >= FILL_FULL)) begin
                state_d = ST_SYNC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q     <= ST_FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sync_q  <= out_sync_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sync  = out_sync_q;
    assign sync      = (state_q == ST_SYNC);

endmodule

// File: tb/tb_sst_descrambler.sv
// Directed bench for sst_descrambler: default 8-bit build plus a 1-bit build,
// checked against hand values and a reference multiplicative scrambler.
module tb_sst_descrambler;
    localparam int unsigned    W    = 8;
    localparam int unsigned    LEN  = 7;
    localparam logic [LEN-1:0] TAPS = 7'b1100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, resync, out_valid, out_ready, out_sync, sync;
    logic [W-1:0] in_data, out_data;

    logic         b_in_valid, b_in_ready, b_resync, b_out_valid, b_out_ready, b_out_sync, b_sync;
    logic [0:0]   b_in_data, b_out_data;

    int unsigned    total  = 0;
    int unsigned    passed = 0;
    int unsigned    failed = 0;
    logic [LEN-1:0] sr;

    sst_descrambler #(.W(W), .LEN(LEN), .TAPS(TAPS)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .resync   (resync),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sync (out_sync),
        .sync     (sync)
    );

    sst_descrambler #(.W(1), .LEN(LEN), .TAPS(TAPS)) u_dut_w1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .resync   (b_resync),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .out_sync (b_out_sync),
        .sync     (b_sync)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] s);
        in_valid = 1'b1;
        in_data  = s;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference transmit-side scrambler; its history is the last LEN scrambled bits.
    task automatic scramble(input logic [W-1:0] d, output logic [W-1:0] s);
        for (int i = 0; i < W; i++) begin
            s[i] = d[i] ^ (^(sr & TAPS));
            sr   = {sr[LEN-2:0], s[i]};
        end
    endtask

    function automatic logic [W-1:0] descr_cold(input logic [W-1:0] s);
        logic [LEN-1:0] r;
        logic [W-1:0]   d;
        r = '0;
        for (int i = 0; i < W; i++) begin
            d[i] = s[i] ^ (^(r & TAPS));
            r    = {r[LEN-2:0], s[i]};
        end
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] src, scr, src_a, src_b, scr_b;
        logic [7:0]   bseq, bexp;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        resync      = 1'b0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_resync    = 1'b0;
        b_out_ready = 1'b1;
        sr          = '0;

        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sync", 64'(out_sync), 64'd0);
        check("rst_sync", 64'(sync), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #10;
        rst_n = 1'b1;
        tick();

        // T1: hand-computed words from a cleared history
        push(8'h01);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'hC1);
        check("t1_out_sync", 64'(out_sync), 64'd0);
        check("t1_sync", 64'(sync), 64'd1);
        push(8'h00);
        check("t1_w2_data", 64'(out_data), 64'h00);
        check("t1_w2_out_sync", 64'(out_sync), 64'd1);
        push(8'h80);
        check("t1_w3_data", 64'(out_data), 64'h80);
        push(8'h00);
        check("t1_w4_data", 64'(out_data), 64'h60);
        tick();
        check("t1_drain", 64'(out_valid), 64'd0);

        // T2: random stream through the reference scrambler, unknown starting history
        sr = LEN'($urandom);
        for (int k = 0; k < 256; k++) begin
            src = W'($urandom);
            scramble(src, scr);
            if ($urandom_range(0, 3) == 0) tick();
            push(scr);
            if (k > 0) check("t2_data", 64'(out_data), 64'(src));
            check("t2_out_sync", 64'(out_sync), 64'd1);
        end
        tick();
        check("t2_drain", 64'(out_valid), 64'd0);

        // T3: back-pressure holds the output word and stalls the input
        out_ready = 1'b0;
        src_a = 8'hA5;
        scramble(src_a, scr);
        push(scr);
        check("t3_first", 64'(out_data), 64'(src_a));
        src_b = 8'h3C;
        scramble(src_b, scr_b);
        in_valid = 1'b1;
        in_data  = scr_b;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t3_in_ready", 64'(in_ready), 64'd0);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_data", 64'(out_data), 64'(src_a));
        end
        out_ready = 1'b1;
        #1;
        check("t3_release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t3_second", 64'(out_data), 64'(src_b));
        check("t3_second_valid", 64'(out_valid), 64'd1);
        tick();
        check("t3_drain", 64'(out_valid), 64'd0);

        // T4: RESYNC together with an accept, then RESYNC alone over a held word
        src = 8'h5A;
        scramble(src, scr);
        resync = 1'b1;
        push(scr);
        resync = 1'b0;
        check("t4_cold_data", 64'(out_data), 64'(descr_cold(scr)));
        check("t4_cold_out_sync", 64'(out_sync), 64'd0);
        check("t4_cold_sync", 64'(sync), 64'd0);
        src = 8'hC3;
        scramble(src, scr);
        push(scr);
        check("t4_next_data", 64'(out_data), 64'(src));
        check("t4_next_out_sync", 64'(out_sync), 64'd1);
        check("t4_next_sync", 64'(sync), 64'd1);
        out_ready = 1'b0;
        resync    = 1'b1;
        tick();
        resync = 1'b0;
        check("t4_alone_sync", 64'(sync), 64'd0);
        check("t4_kept_valid", 64'(out_valid), 64'd1);
        check("t4_kept_data", 64'(out_data), 64'hC3);
        out_ready = 1'b1;
        src = 8'h96;
        scramble(src, scr);
        push(scr);
        check("t4_refill_data", 64'(out_data), 64'(descr_cold(scr)));
        check("t4_refill_out_sync", 64'(out_sync), 64'd0);
        check("t4_refill_sync", 64'(sync), 64'd1);
        src = 8'h4E;
        scramble(src, scr);
        push(scr);
        check("t4_after_data", 64'(out_data), 64'(src));
        check("t4_after_out_sync", 64'(out_sync), 64'd1);
        tick();

        // T5: asynchronous reset drops a held word
        out_ready = 1'b0;
        src = 8'h71;
        scramble(src, scr);
        push(scr);
        tick();
        check("t5_held", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_sync", 64'(sync), 64'd0);
        check("t5_rst_data", 64'(out_data), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t5_no_output", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        push(8'h01);
        check("t5_restart_data", 64'(out_data), 64'hC1);
        check("t5_restart_out_sync", 64'(out_sync), 64'd0);
        check("t5_restart_sync", 64'(sync), 64'd1);

        // T6: single-bit build fills one bit per accept
        check("t6_idle_sync", 64'(b_sync), 64'd0);
        bseq = 8'h01;
        bexp = 8'hC1;
        for (int j = 0; j < 8; j++) begin
            b_in_valid = 1'b1;
            b_in_data  = bseq[j];
            tick();
            b_in_valid = 1'b0;
            check("t6_data", 64'(b_out_data), 64'(bexp[j]));
            check("t6_out_sync", 64'(b_out_sync), 64'(j == 7));
            check("t6_sync", 64'(b_sync), 64'(j >= 6));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
